// File: rtl/reorder_ar_arbiter_if.sv
// Signal bundle between two AXI-style read requesters and a shared reorder buffer.
// Suffixes _i/_o are named from the arbiter's point of view.
interface reorder_ar_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2:0]            s0_arid_i,    s1_arid_i;
    logic                  s0_arvalid_i, s1_arvalid_i;
    logic                  s0_arready_o, s1_arready_o;
    logic [DATA_WIDTH-1:0] s0_rdata_o,   s1_rdata_o;
    logic [2:0]            s0_rid_o,     s1_rid_o;
    logic                  s0_rvalid_o,  s1_rvalid_o;
    logic                  s0_rready_i,  s1_rready_i;
    logic [3:0]            m_arid_o;
    logic                  m_arvalid_o;
    logic                  m_arready_i;
    logic [DATA_WIDTH-1:0] m_rdata_i;
    logic [3:0]            m_rid_i;
    logic                  m_rvalid_i;
    logic                  m_rready_o;
    logic                  idle_o;

    modport slave (
        input  s0_arid_i, s1_arid_i, s0_arvalid_i, s1_arvalid_i,
        output s0_arready_o, s1_arready_o,
        output s0_rdata_o, s1_rdata_o, s0_rid_o, s1_rid_o, s0_rvalid_o, s1_rvalid_o,
        input  s0_rready_i, s1_rready_i,
        output m_arid_o, m_arvalid_o,
        input  m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        output m_rready_o, idle_o
    );

    modport master (
        output s0_arid_i, s1_arid_i, s0_arvalid_i, s1_arvalid_i,
        input  s0_arready_o, s1_arready_o,
        input  s0_rdata_o, s1_rdata_o, s0_rid_o, s1_rid_o, s0_rvalid_o, s1_rvalid_o,
        output s0_rready_i, s1_rready_i,
        input  m_arid_o, m_arvalid_o,
        output m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        input  m_rready_o, idle_o
    );
endinterface

// File: rtl/reorder_ar_arbiter.sv
// Two-requester AR arbiter with per-requester outstanding-read limits and
// combinational R routing by the top bit of the returned ID.
module reorder_ar_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_OUTST  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    reorder_ar_arbiter_if.slave bus
);
    localparam logic [3:0] MaxOutst = 4'(MAX_OUTST);

    logic                  prio_q, prio_d;
    logic                  lock_q, lock_d;
    logic                  gnt_q,  gnt_d;
    logic [3:0]            cnt0_q, cnt0_d;
    logic [3:0]            cnt1_q, cnt1_d;

    logic                  elig0, elig1;
    logic                  gnt, gntValid, arValid, arHs;
    logic                  rSel, rReady, rHs;
    logic                  inc0, inc1, dec0, dec1;
    logic [DATA_WIDTH-1:0] rdata;

    // A locked grant keeps AR valid/ID stable until the reorder buffer accepts it.
    always_comb begin
        elig0    = bus.s0_arvalid_i && (cnt0_q < MaxOutst);
        elig1    = bus.s1_arvalid_i && (cnt1_q < MaxOutst);
        gnt      = 1'b0;
        gntValid = 1'b0;
        arValid  = 1'b0;
        if (lock_q) begin
            gnt      = gnt_q;
            gntValid = 1'b1;
            arValid  = gnt_q ? bus.s1_arvalid_i : bus.s0_arvalid_i;
        end else begin
            gnt      = (elig0 && elig1) ? prio_q : elig1;
            gntValid = elig0 || elig1;
            arValid  = gntValid;
        end
    end

    assign arHs   = arValid && bus.m_arready_i;
    assign rSel   = bus.m_rid_i[3];
    assign rReady = rSel ? bus.s1_rready_i : bus.s0_rready_i;
    assign rHs    = bus.m_rvalid_i && rReady;
    assign rdata  = bus.m_rdata_i;

    assign bus.m_arvalid_o  = rst_n && arValid;
    assign bus.m_arid_o     = {gnt, gnt ? bus.s1_arid_i : bus.s0_arid_i};
    assign bus.s0_arready_o = rst_n && gntValid && !gnt && bus.m_arready_i;
    assign bus.s1_arready_o = rst_n && gntValid &&  gnt && bus.m_arready_i;

    assign bus.m_rready_o   = rst_n && rReady;
    assign bus.s0_rvalid_o  = rst_n && bus.m_rvalid_i && !rSel;
    assign bus.s1_rvalid_o  = rst_n && bus.m_rvalid_i &&  rSel;
    assign bus.s0_rdata_o   = rdata;
    assign bus.s1_rdata_o   = rdata;
    assign bus.s0_rid_o     = bus.m_rid_i[2:0];
    assign bus.s1_rid_o     = bus.m_rid_i[2:0];

    assign bus.idle_o       = (cnt0_q == 4'd0) && (cnt1_q == 4'd0) && !lock_q;

    // An R response at a zero count is a protocol error; the counter holds instead of wrapping.
    always_comb begin
        prio_d = prio_q;
        lock_d = lock_q;
        gnt_d  = gnt_q;
        if (arValid && !bus.m_arready_i) begin
            lock_d = 1'b1;
            gnt_d  = gnt;
        end else if (arHs) begin
            lock_d = 1'b0;
            prio_d = !gnt;
        end

        inc0 = arHs && !gnt;
        inc1 = arHs &&  gnt;
        dec0 = rHs && !rSel && (cnt0_q != 4'd0);
        dec1 = rHs &&  rSel && (cnt1_q != 4'd0);

        cnt0_d = cnt0_q;
        if (inc0 && !dec0 && (cnt0_q != 4'hF)) begin
            cnt0_d = cnt0_q + 4'd1;
        end else if (dec0 && !inc0) begin
            cnt0_d = cnt0_q - 4'd1;
        end

        cnt1_d = cnt1_q;
        if (inc1 && !dec1 && (cnt1_q != 4'hF)) begin
            cnt1_d = cnt1_q + 4'd1;
        end else if (dec1 && !inc1) begin
            cnt1_d = cnt1_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            lock_q <= 1'b0;
            gnt_q  <= 1'b0;
            cnt0_q <= 4'd0;
            cnt1_q <= 4'd0;
        end else begin
            prio_q <= prio_d;
            lock_q <= lock_d;
            gnt_q  <= gnt_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_reorder_ar_arbiter.sv
// Self-checking bench for reorder_ar_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_reorder_ar_arbiter;
    localparam int DW        = 8;
    localparam int MAX_OUTST = 8;

    logic clk;
    logic rst_n;

    reorder_ar_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    reorder_ar_arbiter #(.DATA_WIDTH(DW), .MAX_OUTST(MAX_OUTST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: outstanding reads per requester, lock and round-robin pointer.
    int mCnt [2];
    bit mLock;
    int mGnt;
    int mPrio;

    typedef struct {
        logic       s0v;  logic [2:0] s0id;
        logic       s1v;  logic [2:0] s1id;
        logic       mrdy; logic       rv;   logic [3:0] rid;
        logic       s0rr; logic       s1rr; logic [7:0] rdata;
        logic       eArv; logic [3:0] eArid;
        logic       eS0rdy; logic     eS1rdy;
        logic       eS0rv;  logic     eS1rv; logic eMrr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic s0v, input logic [2:0] s0id, input logic s1v, input logic [2:0] s1id,
                          input logic mrdy, input logic rv, input logic [3:0] rid, input logic s0rr,
                          input logic s1rr, input logic [7:0] rdata, input logic eArv, input logic [3:0] eArid,
                          input logic eS0rdy, input logic eS1rdy, input logic eS0rv, input logic eS1rv,
                          input logic eMrr);
        vec_t v;
        v.s0v = s0v; v.s0id = s0id; v.s1v = s1v; v.s1id = s1id;
        v.mrdy = mrdy; v.rv = rv; v.rid = rid; v.s0rr = s0rr; v.s1rr = s1rr; v.rdata = rdata;
        v.eArv = eArv; v.eArid = eArid; v.eS0rdy = eS0rdy; v.eS1rdy = eS1rdy;
        v.eS0rv = eS0rv; v.eS1rv = eS1rv; v.eMrr = eMrr;
        vecs.push_back(v);
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s0v, input logic [2:0] s0id, input logic s1v, input logic [2:0] s1id,
                                 input logic mrdy, input logic rv, input logic [3:0] rid,
                                 input logic s0rr, input logic s1rr, input logic [7:0] rdata);
        bus.s0_arvalid_i = s0v;  bus.s0_arid_i = s0id;
        bus.s1_arvalid_i = s1v;  bus.s1_arid_i = s1id;
        bus.m_arready_i  = mrdy;
        bus.m_rvalid_i   = rv;   bus.m_rid_i   = rid;
        bus.s0_rready_i  = s0rr; bus.s1_rready_i = s1rr;
        bus.m_rdata_i    = rdata;
    endtask

    // Grant decision from the arbitration rules, using the model state and current inputs.
    task automatic modelGrant(output int g, output bit gv, output bit arv);
        bit av [2];
        bit el [2];
        av[0] = bus.s0_arvalid_i;
        av[1] = bus.s1_arvalid_i;
        for (int n = 0; n < 2; n++) el[n] = av[n] && (mCnt[n] < MAX_OUTST);
        if (mLock) begin
            g   = mGnt;
            gv  = 1'b1;
            arv = av[g];
        end else begin
            gv  = el[0] || el[1];
            g   = (el[0] && el[1]) ? mPrio : (el[1] ? 1 : 0);
            arv = gv;
        end
    endtask

    task automatic modelReset();
        mCnt[0] = 0;
        mCnt[1] = 0;
        mLock   = 1'b0;
        mGnt    = 0;
        mPrio   = 0;
    endtask

    task automatic modelUpdate();
        int g; bit gv; bit arv;
        int sel; bit rr; int old [2];
        modelGrant(g, gv, arv);
        sel = int'(bus.m_rid_i) / 8;
        rr  = (sel == 1) ? bus.s1_rready_i : bus.s0_rready_i;
        old[0] = mCnt[0];
        old[1] = mCnt[1];
        if (arv && !bus.m_arready_i) begin
            mLock = 1'b1;
            mGnt  = g;
        end else if (arv && bus.m_arready_i) begin
            mLock   = 1'b0;
            mPrio   = 1 - g;
            mCnt[g] = mCnt[g] + 1;
        end
        if (bus.m_rvalid_i && rr && old[sel] > 0) mCnt[sel] = mCnt[sel] - 1;
    endtask

    task automatic checkOutput(input string tag);
        int g; bit gv; bit arv; int sel; int id [2];
        modelGrant(g, gv, arv);
        id[0] = int'(bus.s0_arid_i);
        id[1] = int'(bus.s1_arid_i);
        sel   = int'(bus.m_rid_i) / 8;
        checkValue({tag, ".m_arvalid"}, 32'(bus.m_arvalid_o), 32'(arv));
        if (arv) checkValue({tag, ".m_arid"}, 32'(bus.m_arid_o), 32'(g * 8 + id[g]));
        checkValue({tag, ".s0_arready"}, 32'(bus.s0_arready_o), 32'(gv && g == 0 && bus.m_arready_i));
        checkValue({tag, ".s1_arready"}, 32'(bus.s1_arready_o), 32'(gv && g == 1 && bus.m_arready_i));
        checkValue({tag, ".s0_rvalid"}, 32'(bus.s0_rvalid_o), 32'(bus.m_rvalid_i && sel == 0));
        checkValue({tag, ".s1_rvalid"}, 32'(bus.s1_rvalid_o), 32'(bus.m_rvalid_i && sel == 1));
        checkValue({tag, ".m_rready"}, 32'(bus.m_rready_o),
                   32'((sel == 1) ? bus.s1_rready_i : bus.s0_rready_i));
        checkValue({tag, ".s0_rdata"}, 32'(bus.s0_rdata_o), 32'(bus.m_rdata_i));
        checkValue({tag, ".s1_rid"}, 32'(bus.s1_rid_o), 32'(int'(bus.m_rid_i) % 8));
        checkValue({tag, ".idle"}, 32'(bus.idle_o), 32'(mCnt[0] == 0 && mCnt[1] == 0 && !mLock));
    endtask

    // Inputs are driven just after the falling edge; outputs checked before the rising edge.
    task automatic stepCycle(input string tag);
        #1;
        checkOutput(tag);
        modelUpdate();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();

        // Reset state with active inputs: handshake outputs forced low, idle high.
        @(negedge clk);
        applyStimulus(1, 3'd3, 1, 3'd5, 1, 1, 4'h9, 1, 1, 8'h77);
        #1;
        checkValue("rst.m_arvalid", 32'(bus.m_arvalid_o), 0);
        checkValue("rst.s0_arready", 32'(bus.s0_arready_o), 0);
        checkValue("rst.s1_arready", 32'(bus.s1_arready_o), 0);
        checkValue("rst.s1_rvalid", 32'(bus.s1_rvalid_o), 0);
        checkValue("rst.m_rready", 32'(bus.m_rready_o), 0);
        checkValue("rst.idle", 32'(bus.idle_o), 1);
        doReset();

        // Directed vector table.
        addVec(1, 3'd3, 1, 3'd5, 1, 0, 4'h0, 0, 0, 8'h11, 1, 4'h3, 1, 0, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd5, 1, 0, 4'h0, 0, 0, 8'h22, 1, 4'hD, 0, 1, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd5, 1, 0, 4'h0, 0, 0, 8'h33, 1, 4'h3, 1, 0, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd5, 1, 0, 4'h0, 0, 0, 8'h44, 1, 4'hD, 0, 1, 0, 0, 0);
        addVec(0, 3'd0, 0, 3'd0, 0, 1, 4'hE, 0, 0, 8'hA5, 0, 4'h0, 0, 0, 0, 1, 0);
        addVec(0, 3'd0, 1, 3'd2, 0, 0, 4'h0, 0, 0, 8'h00, 1, 4'hA, 0, 0, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd2, 0, 0, 4'h0, 0, 0, 8'h01, 1, 4'hA, 0, 0, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd2, 0, 0, 4'h0, 0, 0, 8'h02, 1, 4'hA, 0, 0, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd2, 1, 0, 4'h0, 0, 0, 8'h03, 1, 4'hA, 0, 1, 0, 0, 0);
        addVec(1, 3'd3, 1, 3'd2, 1, 0, 4'h0, 0, 0, 8'h04, 1, 4'h3, 1, 0, 0, 0, 0);
        addVec(0, 3'd0, 0, 3'd0, 0, 1, 4'h1, 1, 0, 8'h5C, 0, 4'h0, 0, 0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            string tag;
            v   = vecs[i];
            tag = $sformatf("vec%0d", i);
            applyStimulus(v.s0v, v.s0id, v.s1v, v.s1id, v.mrdy, v.rv, v.rid, v.s0rr, v.s1rr, v.rdata);
            #1;
            checkValue({tag, ".m_arvalid"}, 32'(bus.m_arvalid_o), 32'(v.eArv));
            if (v.eArv) checkValue({tag, ".m_arid"}, 32'(bus.m_arid_o), 32'(v.eArid));
            checkValue({tag, ".s0_arready"}, 32'(bus.s0_arready_o), 32'(v.eS0rdy));
            checkValue({tag, ".s1_arready"}, 32'(bus.s1_arready_o), 32'(v.eS1rdy));
            checkValue({tag, ".s0_rvalid"}, 32'(bus.s0_rvalid_o), 32'(v.eS0rv));
            checkValue({tag, ".s1_rvalid"}, 32'(bus.s1_rvalid_o), 32'(v.eS1rv));
            checkValue({tag, ".m_rready"}, 32'(bus.m_rready_o), 32'(v.eMrr));
            checkValue({tag, ".s1_rid"}, 32'(bus.s1_rid_o), 32'(v.rid[2:0]));
            checkValue({tag, ".s0_rdata"}, 32'(bus.s0_rdata_o), 32'(v.rdata));
            modelUpdate();
            @(posedge clk);
            @(negedge clk);
        end

        // Outstanding limit: s0 saturates at MAX_OUTST, one R response re-enables it.
        doReset();
        for (int i = 0; i < MAX_OUTST; i++) begin
            applyStimulus(1, 3'd2, 0, 0, 1, 0, 0, 0, 0, 8'h00);
            stepCycle("lim.fill");
        end
        applyStimulus(1, 3'd2, 1, 3'd5, 1, 0, 0, 0, 0, 8'h00);
        #1;
        checkValue("lim.s1_arid", 32'(bus.m_arid_o), 32'h0D);
        checkValue("lim.s0_arready", 32'(bus.s0_arready_o), 0);
        checkValue("lim.s1_arready", 32'(bus.s1_arready_o), 1);
        stepCycle("lim.s1");
        applyStimulus(1, 3'd2, 0, 0, 0, 1, 4'h1, 1, 0, 8'h3C);
        #1;
        checkValue("lim.s0_blocked", 32'(bus.m_arvalid_o), 0);
        checkValue("lim.r_s0_rvalid", 32'(bus.s0_rvalid_o), 1);
        checkValue("lim.r_m_rready", 32'(bus.m_rready_o), 1);
        stepCycle("lim.r");
        applyStimulus(1, 3'd2, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        #1;
        checkValue("lim.s0_again", 32'(bus.m_arvalid_o), 1);
        checkValue("lim.s0_arid", 32'(bus.m_arid_o), 32'h02);
        stepCycle("lim.again");

        // Same-cycle AR and R on s0 at count 3: count stays 3, so exactly 5 more ARs fit.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'd1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
            stepCycle("both.fill");
        end
        applyStimulus(1, 3'd1, 0, 0, 1, 1, 4'h0, 1, 0, 8'h00);
        stepCycle("both.same");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 3'd1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
            #1;
            checkValue($sformatf("both.ar%0d", i), 32'(bus.m_arvalid_o), 1);
            stepCycle("both.more");
        end
        applyStimulus(1, 3'd1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        #1;
        checkValue("both.full", 32'(bus.m_arvalid_o), 0);
        stepCycle("both.full");

        // Asynchronous reset while s1 is locked with five reads outstanding.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 3'd4, 1, 0, 0, 0, 0, 8'h00);
            stepCycle("ares.fill");
        end
        applyStimulus(0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 8'h00);
        stepCycle("ares.lock");
        applyStimulus(1, 3'd3, 1, 3'd4, 1, 1, 4'hC, 0, 1, 8'h00);
        #1;
        checkOutput("ares.pre");
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("ares.m_arvalid", 32'(bus.m_arvalid_o), 0);
        checkValue("ares.s1_arready", 32'(bus.s1_arready_o), 0);
        checkValue("ares.s1_rvalid", 32'(bus.s1_rvalid_o), 0);
        checkValue("ares.m_rready", 32'(bus.m_rready_o), 0);
        checkValue("ares.idle", 32'(bus.idle_o), 1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 3'd3, 1, 3'd4, 0, 0, 0, 0, 0, 8'h00);
        #1;
        checkValue("ares.post_idle", 32'(bus.idle_o), 1);
        checkValue("ares.post_arid", 32'(bus.m_arid_o), 32'h03);
        stepCycle("ares.post");

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) < 3), 4'($urandom),
                          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7), 8'($urandom));
            stepCycle($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/reorder_ar_arbiter.md
REORDER_AR_ARBITER -- requirements
Module: reorder_ar_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: R data width, matches the downstream reorder buffer.
REQ-002 Parameter MAX_OUTST, default 8: maximum outstanding reads per requester, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s0_arid_i / s1_arid_i  input  3  requester 0/1 read ID.
REQ-006 s0_arvalid_i / s1_arvalid_i  input  1  requester 0/1 AR valid.
REQ-007 s0_arready_o / s1_arready_o  output  1  requester 0/1 AR ready.
REQ-008 s0_rdata_o / s1_rdata_o  output  DATA_WIDTH  requester 0/1 R data.
REQ-009 s0_rid_o / s1_rid_o  output  3  requester 0/1 R ID, equal to m_rid_i[2:0].
REQ-010 s0_rvalid_o / s1_rvalid_o  output  1  requester 0/1 R valid.
REQ-011 s0_rready_i / s1_rready_i  input  1  requester 0/1 R ready.
REQ-012 m_arid_o  output  4  AR ID to the reorder buffer: {requester index, requester ID}.
REQ-013 m_arvalid_o  output  1  AR valid to the reorder buffer.
REQ-014 m_arready_i  input  1  AR ready from the reorder buffer.
REQ-015 m_rdata_i  input  DATA_WIDTH  R data from the reorder buffer.
REQ-016 m_rid_i  input  4  R ID from the reorder buffer.
REQ-017 m_rvalid_i  input  1  R valid from the reorder buffer.
REQ-018 m_rready_o  output  1  R ready to the reorder buffer.
REQ-019 idle_o  output  1  high when both outstanding counters are 0 and no grant is locked.

Function
REQ-020 Requester n is eligible when sn_arvalid_i=1 and cnt_n<MAX_OUTST.
REQ-021 Arbitration state: prio_q (1 bit), lock_q (1 bit), gnt_q (1 bit); all three reset to 0.
REQ-022 Unlocked, one eligible requester: the grant goes to that requester.
REQ-023 Unlocked, both eligible: the grant goes to prio_q.
REQ-024 Unlocked, none eligible: m_arvalid_o=0.
REQ-025 Locked: the grant is gnt_q regardless of other requests (AR valid/ID stability).
REQ-026 m_arvalid_o=1 whenever a grant exists; m_arid_o={gnt, s_gnt_arid_i}.
REQ-027 s_gnt_arready_o=m_arready_i when a grant exists; the non-granted requester's arready is 0.
REQ-028 m_arvalid_o=1 and m_arready_i=0: lock_q<=1 and gnt_q<=current grant on the next edge.
REQ-029 AR handshake (m_arvalid_o and m_arready_i): lock_q<=0, prio_q<=~grant, cnt_grant increments.
REQ-030 Zero-cycle latency on AR: a handshake completes in the same cycle as the request when m_arready_i=1.
REQ-031 Counters cnt_0/cnt_1 are 4 bits wide and reset to 0.
REQ-032 Each R handshake (m_rvalid_i and m_rready_o) decrements cnt_{m_rid_i[3]}.
REQ-033 AR and R handshakes on the same counter in one cycle leave it unchanged.
REQ-034 A counter never wraps; an R handshake at cnt=0 is a protocol error and the counter holds at 0.
REQ-035 R routing is combinational, with no buffering: sel=m_rid_i[3].
REQ-036 s_sel_rvalid_o=m_rvalid_i; the other requester's rvalid is 0.
REQ-037 m_rready_o=s_sel_rready_i.
REQ-038 rdata and rid are broadcast to both requesters: sn_rdata_o=m_rdata_i and sn_rid_o=m_rid_i[2:0].
REQ-039 A locked requester that drops arvalid before handshake is a protocol violation; the block keeps m_arvalid_o equal to the locked requester's arvalid.

Reset
REQ-040 rst_n=0 clears prio_q, lock_q, gnt_q, cnt_0 and cnt_1 immediately, without waiting for a clock edge.
REQ-041 During reset, s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o, m_arvalid_o and m_rready_o are forced to 0, and idle_o is 1.
REQ-042 Reset mid-transaction discards locks and counts; the first cycle after deassertion behaves as power-up.

Verification
REQ-043 Both requesters hold arvalid with IDs 3 and 5, m_arready_i=1 for 4 cycles -> m_arid_o sequence 0x3, 0xD, 0x3, 0xD.
REQ-044 s1 requests with ID 2 while m_arready_i=0 for 3 cycles, and s0 raises arvalid in cycle 2 -> m_arid_o stays 0xA until ready, then s0 is granted.
REQ-045 s0 issues 8 ARs with no R responses -> s0_arready_o=0, s0 is ineligible and s1 is still granted; one R with m_rid_i=0x1 -> s0 is eligible the next cycle.
REQ-046 m_rvalid_i=1, m_rid_i=0xE, s1_rready_i=0 -> s1_rvalid_o=1, s1_rid_o=6, m_rready_o=0, s0_rvalid_o=0.
REQ-047 Same-cycle AR handshake and R handshake for s0 at cnt_0=3 -> cnt_0 remains 3.
REQ-048 rst_n pulled low asynchronously while locked with cnt_1=5 -> outputs clear immediately, and idle_o=1 after release.
